regfile_read_control: RTL

REGFILE_READ_CONTROL -- requirements
Module: regfile_read_control

---
 rtl/regfile_read_control.sv | 116 +++++++++++
 1 files changed

// File: rtl/regfile_read_control.sv
// Register-read stage: 32x32 register file, busy scoreboard, RAW/WAW stall and registered operand
// bundle. Defining REGFILE_BYPASS_EN forwards same-cycle writeback data into the operands.
module regfile_read_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_rs1_data,
  output logic [31:0] out_rs2_data,
  output logic        stall,
  output logic [31:0] stall_cycles
);

  logic [31:0] rf_q [32];
  logic [31:0] busy_q, busy_d;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic        is_writer, use_rs1, use_rs2;
  logic        wb_hit1, wb_hit2, raw1, raw2, waw, fire;
  logic [31:0] rs1_val, rs2_val;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  always_comb begin
    is_writer = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (opcode)
      7'b0110011: begin
        is_writer = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        is_writer = 1'b1;
        use_rs1   = 1'b1;
      end
      7'b0100011, 7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0110111, 7'b0010111, 7'b1101111: is_writer = 1'b1;
      default: ;
    endcase
    if (rd == 5'd0) is_writer = 1'b0;
  end

  assign wb_hit1 = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs1);
  assign wb_hit2 = wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs2);

  // busy_q[0] is held at 0, so x0 sources never raise a hazard.
`ifdef REGFILE_BYPASS_EN
  assign raw1    = use_rs1 && busy_q[rs1] && !wb_hit1;
  assign raw2    = use_rs2 && busy_q[rs2] && !wb_hit2;
  assign rs1_val = wb_hit1 ? wb_data : rf_q[rs1];
  assign rs2_val = wb_hit2 ? wb_data : rf_q[rs2];
`else
  // Without forwarding, a source being written this cycle waits one cycle for the array.
  assign raw1    = use_rs1 && (busy_q[rs1] || wb_hit1);
  assign raw2    = use_rs2 && (busy_q[rs2] || wb_hit2);
  assign rs1_val = rf_q[rs1];
  assign rs2_val = rf_q[rs2];
`endif

  // WAW looks only at the registered busy bit, so a set never meets a clear of the same bit.
  assign waw      = is_writer && busy_q[rd];
  assign stall    = in_valid && (raw1 || raw2 || waw);
  assign in_ready = (!out_valid || out_ready) && !stall;
  assign fire     = in_valid && in_ready;

  always_comb begin
    busy_d = busy_q;
    if (wb_regwrite) busy_d[wb_rd] = 1'b0;
    if (fire && is_writer) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q       <= '0;
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_pc       <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      stall_cycles <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      if (wb_regwrite && (wb_rd != 5'd0)) rf_q[wb_rd] <= wb_data;
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (fire) begin
        out_valid    <= 1'b1;
        out_instr    <= instr;
        out_pc       <= pc;
        out_rs1_data <= use_rs1 ? rs1_val : '0;
        out_rs2_data <= use_rs2 ? rs2_val : '0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
